arbiter_rr_n: RTL and testbench

- N-way round-robin arbiter with packet locking and a registered output stage.
- Merges N_IN valid/ready streams (e.g. engine result or instruction-fetch requests) onto one shared downstream channel.
- Once an input wins, it keeps the grant until a beat with in_last=1 is accepted.
- Output is registered, so there is no combinational path from in_valid/in_data to out_*.

---
 rtl/arbiter_rr_n.sv | 132 +++++++++++++
 tb/tb_arbiter_rr_n.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_rr_n.sv
// arbiter_rr_n: N-way round-robin arbiter with packet locking and a
// registered output stage.
// Optional feature macro: ARB_GRANT_STATS_EN adds per-input saturating
// packet counters on grant_count.
module arbiter_rr_n #(
  parameter int  N_IN   = 4,
  parameter int  DWIDTH = 16,
  parameter int  CNT_W  = 16,
  localparam int SRC_W  = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_IN-1:0]        in_valid,
  input  logic [N_IN*DWIDTH-1:0] in_data,
  input  logic [N_IN-1:0]        in_last,
  output logic [N_IN-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DWIDTH-1:0]      out_data,
  output logic                   out_last,
  output logic [SRC_W-1:0]       out_src,
  input  logic                   out_ready
`ifdef ARB_GRANT_STATS_EN
  ,
  output logic [N_IN*CNT_W-1:0]  grant_count
`endif
);

  // Reject illegal configurations at elaboration time.
  if (N_IN < 2 || N_IN > 16 || CNT_W < 1) begin : g_bad_param
    $error("arbiter_rr_n: N_IN must be 2..16 and CNT_W >= 1");
  end

  typedef enum logic {UNLOCKED, LOCKED} lock_e;

  lock_e                          state_q, state_d;
  logic [SRC_W-1:0]               lock_idx, lock_idx_d;
  logic [SRC_W-1:0]               last_grant, last_grant_d;
  logic [SRC_W-1:0]               rr_idx, sel;
  logic                           sel_ok, can_load, acc, sel_last;
  logic [N_IN-1:0][DWIDTH-1:0]    data_v;

  assign data_v = in_data;

  // First valid index scanning cyclically from lg+1. Walking k downward
  // lets the smallest distance win without a break.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [N_IN-1:0]  v,
                                               input logic [SRC_W-1:0] lg);
    logic [SRC_W-1:0] idx;
    int c;
    idx = '0;
    for (int k = N_IN; k >= 1; k--) begin
      c = (int'(lg) + k) % N_IN;
      if (v[SRC_W'(c)]) idx = SRC_W'(c);
    end
    return idx;
  endfunction

  assign rr_idx   = rr_pick(in_valid, last_grant);
  assign sel      = (state_q == LOCKED) ? lock_idx : rr_idx;
  // A locked input owns the channel even while it is not valid.
  assign sel_ok   = (state_q == LOCKED) || (|in_valid);
  assign can_load = !out_valid || out_ready;
  assign acc      = sel_ok && can_load && in_valid[sel];
  assign sel_last = in_last[sel];

  // One-hot ready towards the selected input only.
  always_comb begin
    in_ready = '0;
    if (sel_ok) in_ready[sel] = can_load;
  end

  // Lock FSM next state: lock on a non-last beat, release on a last beat.
  always_comb begin
    state_d      = state_q;
    lock_idx_d   = lock_idx;
    last_grant_d = last_grant;
    if (acc) begin
      if (sel_last) begin
        state_d      = UNLOCKED;
        last_grant_d = sel;
      end else begin
        state_d    = LOCKED;
        lock_idx_d = sel;
      end
    end
  end

  // Lock FSM state; last_grant starts at N_IN-1 so input 0 goes first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= UNLOCKED;
      lock_idx   <= '0;
      last_grant <= SRC_W'(N_IN - 1);
    end else begin
      state_q    <= state_d;
      lock_idx   <= lock_idx_d;
      last_grant <= last_grant_d;
    end
  end

  // Output stage: load on accept, otherwise drain when downstream takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data  <= data_v[sel];
      out_last  <= sel_last;
      out_src   <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARB_GRANT_STATS_EN
  for (genvar i = 0; i < N_IN; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    // Count completed packets per input, saturating at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        cnt <= '0;
      else if (acc && sel_last && (sel == SRC_W'(i)) && !(&cnt))
        cnt <= cnt + 1'b1;
    end
    assign grant_count[i*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_arbiter_rr_n.sv
// Bench for arbiter_rr_n: table-driven vectors, hand sequences and a
// randomized run against a packet-level reference model. A second
// 3-input instance covers non-power-of-two wrap and mid-packet reset.
module tb_arbiter_rr_n;
  localparam int N = 4, DW = 16, CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, ordy, ov, ol;
  logic [N-1:0]    vld, lst, rdy;
  logic [N*DW-1:0] dat;
  logic [DW-1:0]   od;
  logic [1:0]      os;
`ifdef ARB_GRANT_STATS_EN
  logic [N*CW-1:0] gc;
  logic [3*16-1:0] gc3;
`endif

  logic            rst3_n, or3, ov3, ol3;
  logic [2:0]      v3, l3, r3;
  logic [3*DW-1:0] d3;
  logic [DW-1:0]   od3;
  logic [1:0]      os3;

  arbiter_rr_n #(.N_IN(N), .DWIDTH(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(rst_n), .in_valid(vld), .in_data(dat), .in_last(lst),
    .in_ready(rdy), .out_valid(ov), .out_data(od), .out_last(ol), .out_src(os),
    .out_ready(ordy)
`ifdef ARB_GRANT_STATS_EN
    , .grant_count(gc)
`endif
  );

  arbiter_rr_n #(.N_IN(3), .DWIDTH(DW)) dut3 (
    .clk(clk), .reset_n(rst3_n), .in_valid(v3), .in_data(d3), .in_last(l3),
    .in_ready(r3), .out_valid(ov3), .out_data(od3), .out_last(ol3), .out_src(os3),
    .out_ready(or3)
`ifdef ARB_GRANT_STATS_EN
    , .grant_count(gc3)
`endif
  );

  int n_run = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet-level reference: who owns the channel, who went last, and
  // what the output register currently holds.
  bit            m_ov, m_ol, m_lock;
  logic [DW-1:0] m_od;
  int            m_os, m_lg, m_lidx;

  task automatic model_reset();
    m_ov = 0; m_ol = 0; m_od = '0; m_os = 0;
    m_lock = 0; m_lidx = 0; m_lg = N - 1;
  endtask

  // Called at a negedge with inputs already applied; ends at next negedge.
  task automatic step();
    bit cl, have, acc;
    int sel, c;
    logic [N-1:0] er;
    #1;
    cl = !m_ov || ordy;
    have = 0; sel = 0;
    if (m_lock) begin
      have = 1; sel = m_lidx;
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (m_lg + k) % N;
        if (!have && vld[2'(c)]) begin have = 1; sel = c; end
      end
    end
    er = '0;
    if (have && cl) er[2'(sel)] = 1'b1;
    chk("in_ready", rdy, er);
    acc = have && cl && vld[2'(sel)];
    @(posedge clk);
    if (acc) begin
      m_ov = 1; m_od = dat[sel*DW +: DW]; m_ol = lst[2'(sel)]; m_os = sel;
      if (m_ol) begin m_lock = 0; m_lg = sel; end
      else      begin m_lock = 1; m_lidx = sel; end
    end else if (ordy) begin
      m_ov = 0;
    end
    @(negedge clk);
    chk("out_valid", ov, m_ov);
    if (m_ov) begin
      chk("out_data", od, m_od);
      chk("out_last", ol, m_ol);
      chk("out_src", os, m_os);
    end
  endtask

  // One cycle with hand-derived expectations on top of the model checks.
  task automatic hand(input logic [N-1:0] v, input logic [N-1:0] l, input logic o,
                      input logic [N-1:0] er, input logic eov, input int es);
    vld = v; lst = l; ordy = o;
    #1;
    chk("vec_in_ready", rdy, er);
    chk("ready_onehot", ($countones(rdy) <= 1), 1);
    step();
    chk("vec_out_valid", ov, eov);
    if (es >= 0) chk("vec_out_src", os, es);
  endtask

  task automatic do_reset();
    rst_n = 0; vld = '0; lst = '0; ordy = 1;
    #1;
    chk("rst_out_valid", ov, 0);
    chk("rst_out_data", od, 0);
    chk("rst_out_last", ol, 0);
    chk("rst_out_src", os, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic cyc3(input logic [2:0] v, input logic [2:0] l,
                      input logic [2:0] er, input int es);
    v3 = v; l3 = l;
    #1;
    chk("n3_in_ready", r3, er);
    @(posedge clk);
    @(negedge clk);
    chk("n3_out_valid", ov3, 1);
    chk("n3_out_src", os3, es);
  endtask

  typedef struct {
    logic [N-1:0] v, l;
    logic         o;
    logic [N-1:0] er;
    logic         eov;
    int           es;
  } vec_t;
  vec_t tbl[15];

  initial begin
    for (int r = 0; r < 8; r++)
      tbl[r] = '{4'hF, 4'hF, 1'b1, 4'(1 << (r % 4)), 1'b1, r % 4};
    tbl[8]  = '{4'b0001, 4'hF,    1'b1, 4'b0001, 1'b1, 0};
    tbl[9]  = '{4'b0010, 4'hF,    1'b1, 4'b0010, 1'b1, 1};
    tbl[10] = '{4'hF,    4'b1011, 1'b1, 4'b0100, 1'b1, 2};
    tbl[11] = '{4'hF,    4'b1011, 1'b1, 4'b0100, 1'b1, 2};
    tbl[12] = '{4'hF,    4'hF,    1'b1, 4'b0100, 1'b1, 2};
    tbl[13] = '{4'hF,    4'hF,    1'b1, 4'b1000, 1'b1, 3};
    tbl[14] = '{4'hF,    4'hF,    1'b1, 4'b0001, 1'b1, 0};

    dat = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    rst3_n = 0; v3 = '0; l3 = '0; or3 = 1; d3 = {16'h0C0C, 16'h0B0B, 16'h0A0A};
    @(negedge clk);
    do_reset();

    // Round robin at full rate, then a 3-beat locked packet from input 2.
    foreach (tbl[r]) hand(tbl[r].v, tbl[r].l, tbl[r].o, tbl[r].er, tbl[r].eov, tbl[r].es);

    // Input 1 stalls mid-packet; input 3 must wait for it.
    hand(4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1);
    hand(4'b1000, 4'b1000, 1'b1, 4'b0010, 1'b0, -1);
    hand(4'b1000, 4'b1000, 1'b1, 4'b0010, 1'b0, -1);
    hand(4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b1, 1);
    hand(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 3);

    // Backpressure holds the beat and freezes the inputs.
    dat[15:0] = 16'hA5A5;
    hand(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 0);
    repeat (5) begin
      hand(4'hF, 4'hF, 1'b0, 4'b0000, 1'b1, 0);
      chk("hold_data", od, 16'hA5A5);
      chk("hold_last", ol, 1);
    end
    hand(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1);
    chk("drain_data", od, 16'h2222);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      vld  = 4'($urandom);
      lst  = 4'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      dat  = {$urandom, $urandom};
      step();
    end

`ifdef ARB_GRANT_STATS_EN
    @(negedge clk);
    do_reset();
    repeat (20) hand(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 0);
    chk("gc0_saturated", gc[3:0], 4'hF);
    chk("gc_others_zero", gc[15:4], 12'h000);
`endif

    // Three-input instance: wrap from last_grant=2, then mid-packet reset.
    @(negedge clk);
    rst3_n = 1;
    cyc3(3'b101, 3'b111, 3'b001, 0);
    cyc3(3'b101, 3'b111, 3'b100, 2);
    cyc3(3'b101, 3'b000, 3'b001, 0);
    cyc3(3'b101, 3'b000, 3'b001, 0);
    rst3_n = 0; v3 = 3'b101; l3 = 3'b111;
    #1;
    chk("n3_rst_out_valid", ov3, 0);
    @(negedge clk);
    rst3_n = 1;
    cyc3(3'b101, 3'b111, 3'b001, 0);
    cyc3(3'b111, 3'b111, 3'b010, 1);
    cyc3(3'b101, 3'b111, 3'b100, 2);
    cyc3(3'b111, 3'b111, 3'b001, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
